// File: rtl/cpu_mul_pkg.sv
// Multiply sequencer shared types: op codes, FSM states, default cell latency.
// CPU_MUL_MULX_EN adds the high-word states ISSUE_HI, WAIT_HI and FIX.
package cpu_mul_pkg;

  localparam int CELL_LAT_DEF = 1;

  localparam logic [1:0] MUL_OP_LO  = 2'd0;
  localparam logic [1:0] MUL_OP_XUU = 2'd1;
  localparam logic [1:0] MUL_OP_XSU = 2'd2;
  localparam logic [1:0] MUL_OP_XSS = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
`ifdef CPU_MUL_MULX_EN
    ISSUE_HI,
    WAIT_HI,
    FIX,
`endif
    DONE
  } mul_state_t;

  function automatic logic op_signed_a(
    input logic [1:0] op
  );
    return (op == MUL_OP_XSU) ||
           (op == MUL_OP_XSS);
  endfunction

  function automatic logic op_signed_b(
    input logic [1:0] op
  );
    return op == MUL_OP_XSS;
  endfunction

endpackage

// File: rtl/cpu_mul_combine.sv
// Partial-product combiner: low word, unsigned high word, signed fix-up.
// CPU_MUL_MULX_EN enables the high-word datapath.
module cpu_mul_combine
  import cpu_mul_pkg::*;
(
  input  logic [31:0] p1,
  input  logic [31:0] p2,
  input  logic [31:0] p3,
`ifdef CPU_MUL_MULX_EN
  input  logic [31:0] p4,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_u_q,
  input  logic [1:0]  op,
  output logic [31:0] hi_u,
  output logic [31:0] hi_s,
`endif
  output logic [31:0] lo
);

`ifdef CPU_MUL_MULX_EN
  logic [32:0] mid;
  logic [63:0] full;
  logic [31:0] fix_a;
  logic [31:0] fix_b;

  // middle sum keeps its carry; it lands in bit 48
  assign mid  = {1'b0, p2} + {1'b0, p3};
  assign full = {32'h0, p1}
              + {15'h0, mid, 16'h0}
              + {p4, 32'h0};

  assign lo   = full[31:0];
  assign hi_u = full[63:32];

  assign fix_a = (a[31] && op_signed_a(op))
               ? b : '0;
  assign fix_b = (b[31] && op_signed_b(op))
               ? a : '0;
  assign hi_s  = hi_u_q - fix_a - fix_b;
`else
  logic [31:0] mid;

  assign mid = p2 + p3;
  assign lo  = p1 + (mid << 16);
`endif

endmodule

// File: rtl/cpu_mul_sequencer.sv
// 32x32 multiply sequencer around a 3-partial-product 16x16 cell.
// CPU_MUL_MULX_EN adds the high-word second pass (ops 1-3).
module cpu_mul_sequencer
  import cpu_mul_pkg::*;
#(
  parameter int CELL_LAT = CELL_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [1:0]  req_op,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result
);

  localparam int CW =
    (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(CELL_LAT - 1);

  mul_state_t    state;
  mul_state_t    state_nx;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic [31:0]   lo;

  assign cnt_zero = (cnt == '0);

`ifdef CPU_MUL_MULX_EN
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic [31:0] p1_q;
  logic [31:0] p2_q;
  logic [31:0] p3_q;
  logic [31:0] hi_u_q;
  logic [31:0] hi_u;
  logic [31:0] hi_s;
  logic        pass_lo;
  logic [31:0] c1;
  logic [31:0] c2;
  logic [31:0] c3;

  // lo pass reads the cell live; hi pass reuses the latched P1..P3
  assign pass_lo = (state == WAIT_LO);
  assign c1 = pass_lo ? cell_p1 : p1_q;
  assign c2 = pass_lo ? cell_p2 : p2_q;
  assign c3 = pass_lo ? cell_p3 : p3_q;

  cpu_mul_combine u_comb (
    .p1     (c1),
    .p2     (c2),
    .p3     (c3),
    .p4     (cell_p1),
    .a      (a_q),
    .b      (b_q),
    .hi_u_q (hi_u_q),
    .op     (op_q),
    .hi_u   (hi_u),
    .hi_s   (hi_s),
    .lo     (lo)
  );
`else
  logic unused_op;

  assign unused_op = ^req_op;

  cpu_mul_combine u_comb (
    .p1 (cell_p1),
    .p2 (cell_p2),
    .p3 (cell_p3),
    .lo (lo)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    cell_en   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ISSUE_LO;
      end
      ISSUE_LO: begin
        cell_en  = 1'b1;
        state_nx = WAIT_LO;
      end
      WAIT_LO: begin
        cell_en = 1'b1;
        if (cnt_zero) begin
`ifdef CPU_MUL_MULX_EN
          state_nx = (op_q == MUL_OP_LO)
                   ? DONE : ISSUE_HI;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef CPU_MUL_MULX_EN
      ISSUE_HI: begin
        cell_en  = 1'b1;
        state_nx = WAIT_HI;
      end
      WAIT_HI: begin
        cell_en = 1'b1;
        if (cnt_zero)
          state_nx = (op_q == MUL_OP_XUU)
                   ? DONE : FIX;
      end
      FIX: state_nx = DONE;
`endif
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      cell_src1  <= '0;
      cell_src2  <= '0;
      rsp_result <= '0;
`ifdef CPU_MUL_MULX_EN
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      p3_q       <= '0;
      hi_u_q     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cell_src1 <= req_src1;
            cell_src2 <= req_src2;
`ifdef CPU_MUL_MULX_EN
            a_q       <= req_src1;
            b_q       <= req_src2;
            op_q      <= req_op;
`endif
          end
        end
        ISSUE_LO: cnt <= CNT_INIT;
        WAIT_LO: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
`ifdef CPU_MUL_MULX_EN
            p1_q <= cell_p1;
            p2_q <= cell_p2;
            p3_q <= cell_p3;
            if (op_q == MUL_OP_LO) begin
              rsp_result <= lo;
            end else begin
              cell_src1 <= {16'h0, a_q[31:16]};
              cell_src2 <= {16'h0, b_q[31:16]};
            end
`else
            rsp_result <= lo;
`endif
          end
        end
`ifdef CPU_MUL_MULX_EN
        ISSUE_HI: cnt <= CNT_INIT;
        WAIT_HI: begin
          if (!cnt_zero)
            cnt <= cnt - 1'b1;
          else if (op_q == MUL_OP_XUU)
            rsp_result <= hi_u;
          else
            hi_u_q <= hi_u;
        end
        FIX: rsp_result <= hi_s;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mul_sequencer.sv
// Scoreboard bench: two sequencers (cell latency 1 and 3) with cell models.
// Expected results follow CPU_MUL_MULX_EN as built.
module tb_cpu_mul_sequencer;

`ifdef CPU_MUL_MULX_EN
  localparam bit MULX = 1'b1;
`else
  localparam bit MULX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_src1  [2];
  logic [31:0] req_src2  [2];
  logic [1:0]  req_op    [2];
  logic [31:0] cell_src1 [2];
  logic [31:0] cell_src2 [2];
  logic        cell_en   [2];
  logic [31:0] cell_p1   [2];
  logic [31:0] cell_p2   [2];
  logic [31:0] cell_p3   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result[2];

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_mul_sequencer #(.CELL_LAT(1)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_src1   (req_src1[0]),
    .req_src2   (req_src2[0]),
    .req_op     (req_op[0]),
    .cell_src1  (cell_src1[0]),
    .cell_src2  (cell_src2[0]),
    .cell_en    (cell_en[0]),
    .cell_p1    (cell_p1[0]),
    .cell_p2    (cell_p2[0]),
    .cell_p3    (cell_p3[0]),
    .rsp_valid  (rsp_valid[0]),
    .rsp_ready  (rsp_ready[0]),
    .rsp_result (rsp_result[0])
  );

  cpu_mul_sequencer #(.CELL_LAT(3)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_src1   (req_src1[1]),
    .req_src2   (req_src2[1]),
    .req_op     (req_op[1]),
    .cell_src1  (cell_src1[1]),
    .cell_src2  (cell_src2[1]),
    .cell_en    (cell_en[1]),
    .cell_p1    (cell_p1[1]),
    .cell_p2    (cell_p2[1]),
    .cell_p3    (cell_p3[1]),
    .rsp_valid  (rsp_valid[1]),
    .rsp_ready  (rsp_ready[1]),
    .rsp_result (rsp_result[1])
  );

  for (genvar k = 0; k < 2; k++) begin : g_cell
    localparam int L = (k == 0) ? 1 : 3;
    logic [31:0] q1 [L];
    logic [31:0] q2 [L];
    logic [31:0] q3 [L];
    always @(posedge clk) begin
      if (cell_en[k]) begin
        q1[0] <= 32'(cell_src1[k][15:0])
               * 32'(cell_src2[k][15:0]);
        q2[0] <= 32'(cell_src1[k][15:0])
               * 32'(cell_src2[k][31:16]);
        q3[0] <= 32'(cell_src1[k][31:16])
               * 32'(cell_src2[k][15:0]);
        for (int i = 1; i < L; i++) begin
          q1[i] <= q1[i-1];
          q2[i] <= q2[i-1];
          q3[i] <= q3[i-1];
        end
      end
    end
    assign cell_p1[k] = q1[L-1];
    assign cell_p2[k] = q2[L-1];
    assign cell_p3[k] = q3[L-1];
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  op
  );
    logic [1:0]         o;
    logic [63:0]        uu;
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] sx;
    o  = MULX ? op : 2'd0;
    uu = 64'(a) * 64'(b);
    sa = $signed({{2{a[31]}}, a});
    sb = $signed({2'b00, b});
    if (o == 2'd3) sb = $signed({{2{b[31]}}, b});
    sx = sa * sb;
    case (o)
      2'd0:    return uu[31:0];
      2'd1:    return uu[63:32];
      default: return sx[63:32];
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [1:0] op,
    input int         l
  );
    logic [1:0] o;
    o = MULX ? op : 2'd0;
    if (o == 2'd0) return 1 + l;
    if (o == 2'd1) return 2 + 2 * l;
    return 3 + 2 * l;
  endfunction

  task automatic run(
    input int          k,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  op,
    input int          hold,
    input string       tag
  );
    int          n;
    int          en_cnt;
    int          lat;
    int          en_exp;
    int          bad;
    logic [31:0] r;
    lat    = ref_lat(op, (k == 0) ? 1 : 3);
    en_exp = (MULX && op >= 2'd2) ? lat - 1 : lat;
    @(negedge clk);
    chk({tag, ".rdy_in"}, 32'(req_ready[k]), 1);
    req_valid[k] = 1'b1;
    req_src1[k]  = a;
    req_src2[k]  = b;
    req_op[k]    = op;
    rsp_ready[k] = (hold == 0);
    exp_q.push_back(ref_mul(a, b, op));
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 0;
    en_cnt = 0;
    while (!rsp_valid[k] && n < 60) begin
      if (cell_en[k]) en_cnt++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    if (n >= 60) begin
      void'(exp_q.pop_front());
      return;
    end
    chk({tag, ".en"}, 32'(en_cnt), 32'(en_exp));
    r = rsp_result[k];
    if (hold > 0) begin
      bad = 0;
      req_valid[k] = 1'b1;
      req_src1[k]  = ~a;
      repeat (hold) begin
        @(negedge clk);
        if (rsp_result[k] !== r) bad++;
        if (!rsp_valid[k])       bad++;
        if (req_ready[k])        bad++;
        if (cell_en[k])          bad++;
      end
      chk({tag, ".hold"}, 32'(bad), 0);
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    chk({tag, ".res"}, r, exp_q.pop_front());
    chk({tag, ".rdy_done"},
        32'(req_ready[k]), 0);
    @(negedge clk);
    chk({tag, ".vld_off"}, 32'(rsp_valid[k]), 0);
    chk({tag, ".rdy_back"},
        32'(req_ready[k]), 1);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_src1[k]  = '0;
      req_src2[k]  = '0;
      req_op[k]    = '0;
      rsp_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst.req_ready", 32'(req_ready[k]), 1);
      chk("rst.rsp_valid", 32'(rsp_valid[k]), 0);
      chk("rst.rsp_result", rsp_result[k], 0);
      chk("rst.cell_en", 32'(cell_en[k]), 0);
      chk("rst.cell_src1", cell_src1[k], 0);
      chk("rst.cell_src2", cell_src2[k], 0);
    end
    reset_n = 1'b1;

    run(0, 32'h0000FFFF, 32'h0000FFFF,
        2'd0, 0, "mul_ffff");
    for (int i = 0; i < 4; i++)
      run(0, 32'hFFFFFFFF, 32'hFFFFFFFF,
          2'(i), 0, $sformatf("ones_op%0d", i));
    run(0, 32'h80000000, 32'h80000000,
        2'd3, 0, "min_xss");
    run(0, 32'h80000000, 32'h80000000,
        2'd1, 0, "min_xuu");
    run(0, 32'h00010000, 32'h00010000,
        2'd0, 0, "p16_mul");
    run(0, 32'h00010000, 32'h00010000,
        2'd1, 0, "p16_xuu");
    run(0, 32'h12345678, 32'h9ABCDEF0,
        2'd2, 10, "bp");

    // abort an in-flight high-word multiply
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_src1[0]  = 32'hFFFFFFFF;
    req_src2[0]  = 32'hFFFFFFFF;
    req_op[0]    = 2'd3;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.pre_en", 32'(cell_en[0]),
        MULX ? 32'd1 : 32'd0);
    chk("abort.pre_vld", 32'(rsp_valid[0]),
        MULX ? 32'd0 : 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort.rsp_valid", 32'(rsp_valid[0]), 0);
    chk("abort.cell_en", 32'(cell_en[0]), 0);
    chk("abort.req_ready", 32'(req_ready[0]), 1);
    reset_n = 1'b1;
    rsp_ready[0] = 1'b1;
    run(0, 32'd3, 32'd5, 2'd0, 0, "abort_mul");

    for (int i = 0; i < 8; i++)
      run(0, $urandom, $urandom,
          2'($urandom_range(0, 3)), 0,
          $sformatf("rnd%0d", i));

    run(1, 32'h0000FFFF, 32'h0000FFFF,
        2'd0, 0, "l3_mul");
    run(1, 32'hFFFFFFFF, 32'hFFFFFFFF,
        2'd1, 0, "l3_xuu");
    run(1, 32'hFFFFFFFF, 32'hFFFFFFFF,
        2'd3, 0, "l3_xss");
    run(1, 32'h00010000, 32'h00010000,
        2'd1, 3, "l3_bp");
    for (int i = 0; i < 4; i++)
      run(1, $urandom, $urandom,
          2'($urandom_range(0, 3)), 0,
          $sformatf("l3_rnd%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
